// File: rtl/mm_job_scheduler.sv
// Purpose: round-robin scheduler sharing one 4x4 matmul tile engine across NUM_REQ requesters.
// Latency: grant -> mm_start 1 cycle; response in the cycle after the mm_done rising edge is seen.
// Backpressure: a requester holds req_valid until its one-cycle req_ready; one job in flight at a time.
module mm_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mm_start,
  output logic [IDX_W-1:0]         mm_sel,
  input  logic                     mm_done,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [7:0]               err_count
);

  // Wide enough to hold TIMEOUT_CYC-1 even when TIMEOUT_CYC is a power of two.
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                done_q;
  logic [TAG_W-1:0]    tag_q;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    rr_next;
  logic                done_edge;
  logic                timeout_hit;

  // A done level still high from the previous job never looks like a fresh edge.
  assign done_edge   = mm_done & ~done_q;
  assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));
  assign rr_next     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from rr_ptr downward in priority so the closest set bit wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Job sequencer: state, registered outputs, done edge tracking and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      tag_q     <= '0;
      req_ready <= '0;
      mm_start  <= 1'b0;
      mm_sel    <= '0;
      rsp_valid <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
    end else begin
      done_q    <= mm_done;
      req_ready <= '0;
      mm_start  <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            mm_sel    <= pick_idx;
            rr_ptr    <= rr_next;
            req_ready <= onehot(pick_idx);
            busy      <= 1'b1;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req_valid[mm_sel]) begin
            tag_q    <= req_tag[int'(mm_sel) * TAG_W +: TAG_W];
            mm_start <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            // Requester withdrew: drop the job silently, pointer stays advanced.
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (done_edge) begin
            rsp_valid <= onehot(mm_sel);
            rsp_tag   <= tag_q;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_valid <= onehot(mm_sel);
            rsp_tag   <= tag_q;
            rsp_err   <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Directed bench for mm_job_scheduler: arbitration order, engine handshake,
// done-edge detection, watchdog timeout/saturation, reset abort, abandoned grants.
module tb_mm_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_tag;
  logic [3:0]  req_ready;
  logic        mm_start;
  logic [1:0]  mm_sel;
  logic        mm_done = 1'b0;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  err_count;

  logic [7:0]  tag_tab [4];
  int          n_cmp = 0;
  int          n_err = 0;

  assign req_tag = {tag_tab[3], tag_tab[2], tag_tab[1], tag_tab[0]};

  mm_job_scheduler #(
    .NUM_REQ    (4),
    .TAG_W      (8),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_ready(req_ready),
    .mm_start (mm_start),
    .mm_sel   (mm_sel),
    .mm_done  (mm_done),
    .rsp_valid(rsp_valid),
    .rsp_tag  (rsp_tag),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_mm_start"},  mm_start,  0);
    chk({nm, "_mm_sel"},    mm_sel,    0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_tag"},   rsp_tag,   0);
    chk({nm, "_rsp_err"},   rsp_err,   0);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_err_count"}, err_count, 0);
  endtask

  task automatic do_reset(input string nm);
    rst_n     = 1'b0;
    req_valid = '0;
    mm_done   = 1'b0;
    repeat (2) cycle();
    chk_idle_outputs(nm);
    rst_n = 1'b1;
  endtask

  // Bounded wait for the next grant; expects exactly requester exp_idx.
  task automatic await_grant(input string nm, input int exp_idx);
    int n = 0;
    cycle();
    while (req_ready == 4'b0 && n < 4) begin
      cycle();
      n++;
    end
    chk({nm, "_grant"}, req_ready, 32'(1 << exp_idx));
    chk({nm, "_sel"},   mm_sel,    exp_idx);
  endtask

  // One full job. dly<0: engine never finishes (64 WAIT cycles, then timeout).
  // dly>=0: mm_done driven high in the dly-th WAIT cycle; low_at drops it earlier.
  task automatic serve(input string nm, input int exp_idx, input int dly,
                       input int low_at, input bit exp_err);
    int extra = 0;
    int n_wait;
    await_grant(nm, exp_idx);
    cycle();
    chk({nm, "_start"}, mm_start, 1);
    n_wait = (dly < 0) ? 64 : dly;
    for (int i = 1; i <= n_wait; i++) begin
      cycle();
      if (mm_start || rsp_valid != 4'b0 || req_ready != 4'b0) extra++;
      if (i == low_at) mm_done = 1'b0;
    end
    chk({nm, "_quiet"}, extra, 0);
    if (dly >= 0) mm_done = 1'b1;
    cycle();
    chk({nm, "_rsp_valid"}, rsp_valid, 32'(1 << exp_idx));
    chk({nm, "_rsp_tag"},   rsp_tag,   tag_tab[exp_idx]);
    chk({nm, "_rsp_err"},   rsp_err,   exp_err);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    tag_tab[0] = 8'h5A;
    tag_tab[1] = 8'hA1;
    tag_tab[2] = 8'hB2;
    tag_tab[3] = 8'hC3;

    do_reset("rst0");

    // Single job from requester 0, done 33 cycles after start.
    req_valid = 4'b0001;
    serve("t1", 0, 33, -1, 1'b0);
    mm_done = 1'b0;
    // Done edge in the final allowed WAIT cycle beats the watchdog.
    serve("t1_edge64", 0, 64, -1, 1'b0);
    chk("t1_edge64_errcnt", err_count, 0);
    mm_done   = 1'b0;
    req_valid = '0;

    // All four pending: strict rotation 0,1,2,3 then wrap to 0.
    do_reset("rst1");
    req_valid = 4'b1111;
    serve("t2_j0", 0, 33, -1, 1'b0); mm_done = 1'b0;
    serve("t2_j1", 1, 33, -1, 1'b0); mm_done = 1'b0;
    serve("t2_j2", 2, 33, -1, 1'b0); mm_done = 1'b0;
    serve("t2_j3", 3, 33, -1, 1'b0); mm_done = 1'b0;
    serve("t2_j4", 0, 33, -1, 1'b0); mm_done = 1'b0;
    req_valid = '0;

    // Watchdog timeout and saturating error counter.
    req_valid = 4'b0001;
    serve("t3_to", 0, -1, -1, 1'b1);
    chk("t3_errcnt1", err_count, 1);
    for (int j = 0; j < 254; j++) serve("t3_loop", 0, -1, -1, 1'b1);
    chk("t3_errcnt255", err_count, 255);
    for (int j = 0; j < 6; j++) serve("t3_sat", 0, -1, -1, 1'b1);
    chk("t3_errcnt_sat", err_count, 255);
    req_valid = '0;

    // Left-over done level must not complete the next job.
    do_reset("rst2");
    req_valid = 4'b0001;
    serve("t4_a", 0, 10, -1, 1'b0);
    req_valid = 4'b0010;
    serve("t4_b", 1, 30, 20, 1'b0);
    mm_done   = 1'b0;
    req_valid = '0;

    // Reset in WAIT aborts silently; requester 2 is then served normally.
    req_valid = 4'b1000;
    await_grant("t5", 3);
    cycle();
    chk("t5_start", mm_start, 1);
    req_valid = '0;
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    chk_idle_outputs("t5_rst");
    rst_n = 1'b1;
    extra = 0;
    repeat (3) begin
      cycle();
      if (rsp_valid != 4'b0 || mm_start || busy) extra++;
    end
    chk("t5_post_quiet", extra, 0);
    req_valid = 4'b0100;
    serve("t5_r2", 2, 33, -1, 1'b0);
    mm_done   = 1'b0;
    req_valid = '0;

    // Requester 1 withdraws in its GRANT cycle: no start, no response, pointer advanced.
    req_valid = 4'b0010;
    await_grant("t6", 1);
    req_valid = '0;
    extra = 0;
    repeat (6) begin
      cycle();
      if (mm_start || rsp_valid != 4'b0 || req_ready != 4'b0) extra++;
    end
    chk("t6_abandon_quiet", extra, 0);
    chk("t6_busy", busy, 0);
    req_valid = 4'b1011;
    serve("t6_next", 3, 33, -1, 1'b0);
    mm_done   = 1'b0;
    req_valid = '0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
